// File: rtl/multdiv_seq.sv
// multdiv_seq: control sequencer for the shared iterative multiply/divide datapath.
//
// It accepts one-cycle start pulses (ctrl_MULT / ctrl_DIV) and walks
// IDLE -> LOAD -> RUN (ITER steps) -> FIX -> DONE -> IDLE. The datapath enables
// (load, step_en, fix_en) and the result handshake are decoded from the state
// register only. A new start in any state restarts the unit from LOAD.
//
// Build option: define MULTDIV_DIVZERO_TRAP_EN to trap divide-by-zero. A trapped
// divide jumps straight to DONE and raises data_exception with the ready pulse.
// Without the macro, divisor_zero is ignored and a divide by zero runs the full
// sequence like any other op.
module multdiv_seq #(
    parameter int ITER = 32,
    parameter int CW   = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctrl_MULT,
    input  logic          ctrl_DIV,
    input  logic          divisor_zero,
    input  logic          op_a_neg,
    input  logic          op_b_neg,
    output logic          load,
    output logic          step_en,
    output logic          is_div,
    output logic          negate_result,
    output logic          fix_en,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          data_resultRDY,
    output logic          data_exception
);

    // The iteration counter has to reach ITER-1 without wrapping early.
    if ((1 << CW) <= ITER) begin : g_bad_cw
        $error("multdiv_seq: CW too small for ITER");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(ITER - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count_next;
    logic          start;
    logic          div_sel;
    logic          exc_start;
    logic          is_div_q;
    logic          negate_q;
    logic          exc_q;

    // Start decode: multiply wins when both pulses arrive in the same cycle.
    always_comb begin
        start   = ctrl_MULT | ctrl_DIV;
        div_sel = ctrl_DIV & ~ctrl_MULT;
    end

`ifdef MULTDIV_DIVZERO_TRAP_EN
    // Only a genuine divide (not the multiply-wins case) can trap.
    always_comb begin
        exc_start = div_sel & divisor_zero;
    end

    // Exception latch, reloaded on every start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_q <= 1'b0;
        end else if (start) begin
            exc_q <= exc_start;
        end
    end
`else
    // Trapping disabled: the exception path is tied off.
    logic unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;

    always_comb begin
        exc_start = 1'b0;
    end

    assign exc_q = 1'b0;
`endif

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic; a start overrides whatever the FSM was doing.
    always_comb begin
        state_next = state;
        count_next = '0;
        if (start) begin
            state_next = exc_start ? DONE : LOAD;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                LOAD: state_next = RUN;
                RUN: begin
                    if (count == LAST_STEP) begin
                        state_next = FIX;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Op-type and sign fix-up latches, captured from the start cycle operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div_q <= 1'b0;
            negate_q <= 1'b0;
        end else if (start) begin
            is_div_q <= div_sel;
            negate_q <= op_a_neg ^ op_b_neg;
        end
    end

    // Moore output decode; latched fields are hidden while idle so IDLE reads all-zero.
    always_comb begin
        load           = (state == LOAD);
        step_en        = (state == RUN);
        fix_en         = (state == FIX);
        busy           = (state == LOAD) || (state == RUN) || (state == FIX);
        data_resultRDY = (state == DONE);
        data_exception = (state == DONE) && exc_q;
        is_div         = (state != IDLE) && is_div_q;
        negate_result  = (state != IDLE) && negate_q;
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Top-level sequencer for the shared iterative multiply/divide datapath: accepts one-cycle start pulses from the pipeline and drives operand load, per-iteration step enables, sign fix-up and the ready/exception handshake.
- Replaces ad-hoc free-running counters with an explicit FSM, so a new op can restart the unit cleanly and divide-by-zero is trapped.

Parameters:
- ITER, 32, iterations per op (shift/add or restoring-divide steps)
- CW, 6, counter width; must satisfy 2^CW > ITER

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- ctrl_MULT  in  1  one-cycle pulse: start multiply
- ctrl_DIV  in  1  one-cycle pulse: start divide
- divisor_zero  in  1  operand B == 0, valid in the start cycle
- op_a_neg  in  1  operand A sign bit, valid in the start cycle
- op_b_neg  in  1  operand B sign bit, valid in the start cycle
- load  out  1  datapath loads operand/abs registers
- step_en  out  1  datapath performs one iteration
- is_div  out  1  latched op type: 1 = divide, 0 = multiply
- negate_result  out  1  latched sign fix-up = op_a_neg ^ op_b_neg
- fix_en  out  1  datapath applies conditional negate to result
- count  out  CW  iteration index within RUN
- busy  out  1  op in progress
- data_resultRDY  out  1  one-cycle result-valid pulse
- data_exception  out  1  divide-by-zero, qualified by data_resultRDY

Behaviour:
- States: IDLE, LOAD, RUN, FIX, DONE. Moore outputs are decoded from the state register.
- Reset (reset=0): state=IDLE, count=0, is_div=0, negate_result=0, exc latch=0. All outputs are 0.
- start = ctrl_MULT | ctrl_DIV, sampled every rising edge in every state.
- If both pulses are asserted in the same cycle, multiply wins: is_div=0.
- On start, the FSM latches is_div, negate_result and exc = ctrl_DIV & ~ctrl_MULT & divisor_zero.
- Next state after start:
  - DONE if exc=1.
  - LOAD otherwise.
  - count is cleared to 0.
- LOAD: load=1, busy=1. Next state is RUN.
- RUN: step_en=1, busy=1, count increments each cycle.
  - When count==ITER-1, next state is FIX and count wraps to 0.
  - RUN lasts exactly ITER cycles.
- FIX: fix_en=1, busy=1. Next state is DONE.
- DONE: data_resultRDY=1, data_exception=exc latch, busy=0. Next state is IDLE.
- Latency, start edge E0 to RDY:
  - Normal op: RDY is high in the cycle after edge E0+ITER+2, i.e. 34 cycles for ITER=32.
  - Divide-by-zero: RDY and exception are high in the cycle after E0.
- Restart: a start in LOAD, RUN, FIX or DONE aborts the current op with no RDY for it.
  - Latches are reloaded and the sequence restarts exactly as from IDLE.
  - A start during DONE still lets that cycle's RDY pulse complete.
- divisor_zero, op_a_neg and op_b_neg are don't-care outside start cycles.
- Latched values are stable from LOAD through DONE.
- Reset mid-operation: reset low forces IDLE immediately and asynchronously. No RDY is produced.
- count is held at 0 outside RUN.
- IDLE holds indefinitely with all outputs at 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MULTDIV_DIVZERO_TRAP_EN.
- Defined:
  - Divide-by-zero short-circuits to DONE with data_exception=1, as above.
- Undefined:
  - divisor_zero is ignored and the exc latch is tied to 0.
  - data_exception is constant 0.
  - A divide by zero runs the full LOAD/RUN/FIX sequence with the normal 34-cycle latency, and the datapath result is undefined.

Test Plan:
- Reset low for 3 cycles, then release -> all outputs 0, state IDLE, no RDY for 50 idle cycles.
- ctrl_MULT pulse, op_a_neg=1, op_b_neg=0 -> load high 1 cycle, step_en high 32 cycles with count 0..31, fix_en 1 cycle, RDY pulse 34 cycles after start; negate_result=1, is_div=0, data_exception=0.
- ctrl_DIV pulse, divisor_zero=1 (macro defined) -> RDY=1 and data_exception=1 on the next cycle, busy never asserted.
  - Same stimulus with macro undefined -> RDY at 34 cycles, data_exception=0.
- ctrl_DIV pulse, then ctrl_MULT pulse at RUN count=10 -> no RDY for the divide; is_div=0; RDY exactly 34 cycles after the second pulse.
- ctrl_MULT and ctrl_DIV pulsed together with divisor_zero=1 -> treated as multiply: is_div=0, full 34-cycle latency, data_exception=0.
- Start ctrl_DIV, drop reset asynchronously (between edges) at count=20 -> outputs go 0 immediately.
  - After release, no RDY occurs.
  - A new ctrl_MULT then completes normally in 34 cycles.
